muldiv_sequencer: RTL and testbench

//  Multi-cycle controller and datapath for RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.

---
 rtl/muldiv_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: one result bit per cycle (shift-add multiply, restoring divide).
// Optional MULDIV_EARLY_OUT_EN: trivial operands (zero, divide-by-zero, signed overflow) finish in one cycle.
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam int unsigned PW = 2 * XLEN;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;
    logic            divz_q, divz_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            sa_in, sb_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   mul_sum;
    logic [PW-1:0]   mul_next, div_next, prod_s;
    logic [XLEN:0]   rem_t;
    logic            div_ge;
    logic [XLEN-1:0] rem_n, quo, rem, fix_res;

    // Operand sign handling: MULH/DIV/REM signed both, MULHSU signed rs1 only.
    always_comb begin
        sa_in = ((funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                 (funct3_i == 3'b100) || (funct3_i == 3'b110)) && rs1_i[XLEN-1];
        sb_in = ((funct3_i == 3'b001) || (funct3_i == 3'b100) ||
                 (funct3_i == 3'b110)) && rs2_i[XLEN-1];
        a_mag = sa_in ? XLEN'('0 - rs1_i) : rs1_i;
        b_mag = sb_in ? XLEN'('0 - rs2_i) : rs2_i;
    end

    // One iteration of each algorithm, plus the sign fix-up of the final values.
    always_comb begin
        mul_sum  = {1'b0, prod_q[PW-1:XLEN]} + (prod_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, prod_q[XLEN-1:1]};
        rem_t    = prod_q[PW-1:XLEN-1];
        div_ge   = rem_t >= {1'b0, opb_q};
        rem_n    = div_ge ? XLEN'(rem_t - {1'b0, opb_q}) : rem_t[XLEN-1:0];
        div_next = {rem_n, prod_q[XLEN-2:0], div_ge};
        prod_s   = (neg_a_q ^ neg_b_q) ? PW'('0 - prod_q) : prod_q;
        quo      = prod_q[XLEN-1:0];
        rem      = prod_q[PW-1:XLEN];
        if (!op_q[2]) begin
            fix_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[PW-1:XLEN];
        end else if (!op_q[1]) begin
            fix_res = divz_q ? '1 : ((neg_a_q ^ neg_b_q) ? XLEN'('0 - quo) : quo);
        end else begin
            fix_res = neg_a_q ? XLEN'('0 - rem) : rem;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        divz_d   = divz_q;
        opb_d    = opb_q;
        prod_d   = prod_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                    op_d    = funct3_i;
                    neg_a_d = sa_in;
                    neg_b_d = sb_in;
                    divz_d  = (rs2_i == '0);
                    busy_d  = 1'b1;
                    if (funct3_i[2]) begin
                        opb_d  = b_mag;
                        prod_d = {{XLEN{1'b0}}, a_mag};
                    end else begin
                        opb_d  = a_mag;
                        prod_d = {{XLEN{1'b0}}, b_mag};
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    if (funct3_i[2]) begin
                        if (rs2_i == '0) begin
                            state_d  = S_DONE;
                            done_d   = 1'b1;
                            result_d = funct3_i[1] ? rs1_i : '1;
                        end else if (!funct3_i[0] && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                                     (rs2_i == '1)) begin
                            state_d  = S_DONE;
                            done_d   = 1'b1;
                            result_d = funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        end
                    end else if ((rs1_i == '0) || (rs2_i == '0)) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = '0;
                    end
`endif
                end
            end
            S_CALC: begin
                prod_d = op_q[2] ? div_next : mul_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = fix_res;
                state_d  = S_DONE;
                done_d   = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
        // Flush wins over everything, including a same-cycle start.
        if (flush_i) begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            divz_q   <= 1'b0;
            opb_q    <= '0;
            prod_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            divz_q   <= divz_d;
            opb_q    <= opb_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign stall_o  = (start_i && (state_q == S_IDLE)) || (busy_q && (state_q != S_DONE));

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M corner cases plus random ops vs. an arithmetic model.
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        flush_i;
    logic        busy_o;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] last_res = 32'h0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'h0, a};
        longint unsigned ub = {32'h0, b};
        logic [63:0]     p;
        logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = ua * ub;            return p[31:0];  end
            3'd1: begin p = sa * sb;            return p[63:32]; end
            3'd2: begin p = sa * longint'(ub);  return p[63:32]; end
            3'd3: begin p = ua * ub;            return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'h0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (f[2] && (b == 32'h0)) return 1;
        if (f[2] && !f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
        if (!f[2] && ((a == 32'h0) || (b == 32'h0))) return 1;
`endif
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op from IDLE (called #1 after a rising edge), follow it to done_o and check everything.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit poke_busy, input bit start_at_done);
        logic [31:0] exp = ref_model(f, a, b);
        int          lat = latency(f, a, b);
        int          done_at = 0;
        int          stall_err = 0;
        logic [31:0] got = 32'hx;
        funct3_i = f; rs1_i = a; rs2_i = b; start_i = 1'b1;
        #1;
        chk("stall_at_T", 32'(stall_o), 32'h1);
        @(posedge clk); #1;
        start_i = 1'b0; rs1_i = $urandom; rs2_i = $urandom; funct3_i = 3'($urandom);
        for (int k = 1; k <= 60; k++) begin
            if (stall_o !== (k < lat)) stall_err++;
            if (done_o === 1'b1) begin
                done_at = k;
                got = result_o;
                break;
            end
            if (poke_busy && k == 5) begin
                start_i = 1'b1; funct3_i = 3'($urandom); rs1_i = $urandom; rs2_i = $urandom;
            end
            if (k == 6) start_i = 1'b0;
            @(posedge clk); #1;
        end
        chk("latency", 32'(done_at), 32'(lat));
        chk("result", got, exp);
        chk("stall_window", 32'(stall_err), 32'h0);
        chk("busy_at_done", 32'(busy_o), 32'h1);
        if (start_at_done) begin
            start_i = 1'b1; funct3_i = 3'd0; rs1_i = 32'd9; rs2_i = 32'd9;
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("busy_after_done", 32'(busy_o), 32'h0);
        chk("done_pulse_width", 32'(done_o), 32'h0);
        chk("result_held", result_o, exp);
        last_res = exp;
    endtask

    initial begin
        int saw_done;
        rst_n = 1'b0; start_i = 1'b0; funct3_i = 3'd0; rs1_i = 32'h0; rs2_i = 32'h0; flush_i = 1'b0;
        #12;
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_done", 32'(done_o), 32'h0);
        chk("rst_result", result_o, 32'h0);
        chk("rst_stall", 32'(stall_o), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b1);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        do_op(3'd5, 32'd100, 32'd7, 1'b0, 1'b0);
        do_op(3'd7, 32'd100, 32'd7, 1'b0, 1'b0);
        do_op(3'd4, 32'd5, 32'd0, 1'b0, 1'b0);
        do_op(3'd6, 32'd5, 32'd0, 1'b0, 1'b0);
        do_op(3'd4, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Flush at T+10: idle at T+11 with no done_o and result untouched, restart at T+12.
        funct3_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd4; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        saw_done = 0;
        repeat (9) begin
            if (done_o === 1'b1) saw_done++;
            @(posedge clk); #1;
        end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush_busy", 32'(busy_o), 32'h0);
        chk("flush_done", 32'(done_o), 32'h0);
        chk("flush_no_early_done", 32'(saw_done), 32'h0);
        chk("flush_result", result_o, last_res);
        @(posedge clk); #1;
        do_op(3'd5, 32'd1000, 32'd33, 1'b0, 1'b0);

        // Async reset in the middle of an op.
        funct3_i = 3'd4; rs1_i = 32'd77; rs2_i = 32'd5; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midop_rst_busy", 32'(busy_o), 32'h0);
        chk("midop_rst_result", result_o, 32'h0);
        chk("midop_rst_done", 32'(done_o), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f = 3'($urandom);
            logic [31:0] a = pick();
            logic [31:0] b = pick();
            do_op(f, a, b, 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
